// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and WIDTH limits for serial_subtractor_ctrl
package serial_sub_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;
endpackage

// File: rtl/full_subtractor_1bit.sv
// full_subtractor_1bit: single-bit difference and borrow
module full_subtractor_1bit (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);
  assign d = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);
endmodule

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial a - b - b_in, LSB first; SERIAL_SUB_FLAGS_EN adds zero/ovf
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next;
  logic [CW-1:0] cnt;
  logic brw, cd, cb, last;
  full_subtractor_1bit u_cell (.a(a_sh[0]), .b(b_sh[0]), .b_in(brw), .d(cd), .b_out(cb));
  // Difference bits enter at the MSB so the LSB-first result lands aligned after WIDTH shifts
  if (WIDTH == 1) begin : g_w1
    assign r_next = cd;
  end else begin : g_wn
    assign r_next = {cd, r_sh[WIDTH-1:1]};
  end
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      d <= '0;
      b_out <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      cnt <= '0;
      brw <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      zero <= 1'b0;
      ovf <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_RUN;
          busy <= 1'b1;
          a_sh <= a;
          b_sh <= b;
          brw <= b_in;
          cnt <= '0;
        end
        ST_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_next;
          brw <= cb;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= ST_DONE;
            done <= 1'b1;
            d <= r_next;
            b_out <= cb;
`ifdef SERIAL_SUB_FLAGS_EN
            zero <= r_next == '0;
            ovf <= brw ^ cb;
`endif
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: randomized and directed checks of WIDTH=8 and WIDTH=1 instances
module tb_serial_subtractor_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic s8 = 1'b0, bi8 = 1'b0, busy8, done8, bo8;
  logic [7:0] a8 = '0, b8 = '0, d8;
  logic s1 = 1'b0, a1 = 1'b0, b1 = 1'b0, bi1 = 1'b0, busy1, done1, d1, bo1;
`ifdef SERIAL_SUB_FLAGS_EN
  logic z8, o8, z1, o1;
`endif
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;
  serial_subtractor_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .b_in(bi8),
    .busy(busy8), .done(done8), .d(d8), .b_out(bo8)
`ifdef SERIAL_SUB_FLAGS_EN
    , .zero(z8), .ovf(o8)
`endif
  );
  serial_subtractor_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(s1), .a(a1), .b(b1), .b_in(bi1),
    .busy(busy1), .done(done1), .d(d1), .b_out(bo1)
`ifdef SERIAL_SUB_FLAGS_EN
    , .zero(z1), .ovf(o1)
`endif
  );
  // One operation on the chosen instance, checking handshake timing, held result and final value
  task automatic run_op(input bit w1, input logic [7:0] ta, input logic [7:0] tv, input logic tbin);
    int wd, diff, sa, sb, sres;
    logic [7:0] mask, am, bm, prev_d, exp_d, od;
    logic exp_bo, obusy, odone, obo;
    wd = w1 ? 1 : 8;
    mask = w1 ? 8'h01 : 8'hFF;
    am = ta & mask;
    bm = tv & mask;
    diff = int'(am) - int'(bm) - int'(tbin);
    exp_d = 8'(diff) & mask;
    exp_bo = diff < 0;
    @(negedge clk);
    prev_d = w1 ? {7'b0, d1} : d8;
    if (w1) begin a1 = am[0]; b1 = bm[0]; bi1 = tbin; s1 = 1'b1; end
    else begin a8 = am; b8 = bm; bi8 = tbin; s8 = 1'b1; end
    for (int j = 1; j <= wd + 1; j++) begin
      @(negedge clk);
      if (j == 1) begin
        s1 = 1'b0;
        s8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); bi1 = 1'($urandom);
      end
      obusy = w1 ? busy1 : busy8;
      odone = w1 ? done1 : done8;
      od = w1 ? {7'b0, d1} : d8;
      obo = w1 ? bo1 : bo8;
      n_cmp++;
      if (obusy !== 1'b1) begin n_fail++; $display("FAIL busy w%0d cyc%0d got %b want 1", wd, j, obusy); end
      n_cmp++;
      if (odone !== (j == wd + 1)) begin n_fail++; $display("FAIL done w%0d cyc%0d got %b want %b", wd, j, odone, j == wd + 1); end
      n_cmp++;
      if (j <= wd) begin
        if (od !== prev_d) begin n_fail++; $display("FAIL hold_d w%0d cyc%0d got %h want %h", wd, j, od, prev_d); end
      end else begin
        if (od !== exp_d) begin n_fail++; $display("FAIL d w%0d %h-%h-%b got %h want %h", wd, am, bm, tbin, od, exp_d); end
        n_cmp++;
        if (obo !== exp_bo) begin n_fail++; $display("FAIL b_out w%0d %h-%h-%b got %b want %b", wd, am, bm, tbin, obo, exp_bo); end
`ifdef SERIAL_SUB_FLAGS_EN
        sa = am[wd-1] ? int'(am) - (1 << wd) : int'(am);
        sb = bm[wd-1] ? int'(bm) - (1 << wd) : int'(bm);
        sres = sa - sb - int'(tbin);
        n_cmp++;
        if ((w1 ? z1 : z8) !== (exp_d == 8'h00)) begin n_fail++; $display("FAIL zero w%0d got %b want %b", wd, w1 ? z1 : z8, exp_d == 8'h00); end
        n_cmp++;
        if ((w1 ? o1 : o8) !== (sres < -(1 << (wd - 1)) || sres >= (1 << (wd - 1)))) begin
          n_fail++; $display("FAIL ovf w%0d %h-%h-%b got %b", wd, am, bm, tbin, w1 ? o1 : o8);
        end
`else
        sa = 0; sb = 0; sres = sa + sb;
`endif
      end
    end
    @(negedge clk);
    n_cmp++;
    if ((w1 ? busy1 : busy8) !== 1'b0 || (w1 ? done1 : done8) !== 1'b0) begin
      n_fail++; $display("FAIL idle_after w%0d busy %b done %b want 0 0", wd, w1 ? busy1 : busy8, w1 ? done1 : done8);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy8, done8, d8, bo8} !== 11'd0) begin n_fail++; $display("FAIL reset8 got %b want 0", {busy8, done8, d8, bo8}); end
    n_cmp++;
    if ({busy1, done1, d1, bo1} !== 4'd0) begin n_fail++; $display("FAIL reset1 got %b want 0", {busy1, done1, d1, bo1}); end
`ifdef SERIAL_SUB_FLAGS_EN
    n_cmp++;
    if ({z8, o8, z1, o1} !== 4'd0) begin n_fail++; $display("FAIL reset_flags got %b want 0", {z8, o8, z1, o1}); end
`endif
    rst = 1'b0;
  endtask
  task automatic test_directed();
    run_op(1'b0, 8'h5A, 8'h33, 1'b0);
    run_op(1'b0, 8'h10, 8'h20, 1'b0);
    run_op(1'b0, 8'h00, 8'h00, 1'b1);
    run_op(1'b0, 8'h80, 8'h01, 1'b0);
    run_op(1'b0, 8'h7F, 8'h7F, 1'b0);
    run_op(1'b0, 8'hFF, 8'hFF, 1'b1);
  endtask
  task automatic test_held_start();
    logic [7:0] oa[3], ob[3], ed[3];
    logic obi[3], eb[3];
    int pulses = 0;
    for (int k = 0; k < 3; k++) begin
      oa[k] = 8'($urandom); ob[k] = 8'($urandom); obi[k] = 1'($urandom);
      ed[k] = 8'(int'(oa[k]) - int'(ob[k]) - int'(obi[k]));
      eb[k] = int'(oa[k]) < int'(ob[k]) + int'(obi[k]);
    end
    for (int j = 0; j <= 30; j++) begin
      @(negedge clk);
      if (j > 0) begin
        n_cmp++;
        if (done8 !== (j % 10 == 9)) begin n_fail++; $display("FAIL held_done cyc%0d got %b want %b", j, done8, j % 10 == 9); end
        if (done8 === 1'b1) begin
          pulses++;
          n_cmp++;
          if (d8 !== ed[j / 10] || bo8 !== eb[j / 10]) begin
            n_fail++; $display("FAIL held_result op%0d got %h/%b want %h/%b", j / 10, d8, bo8, ed[j / 10], eb[j / 10]);
          end
        end
      end
      s8 = j < 30;
      if (j % 10 == 0 && j < 30) begin a8 = oa[j / 10]; b8 = ob[j / 10]; bi8 = obi[j / 10]; end
      else begin a8 = 8'($urandom); b8 = 8'($urandom); bi8 = 1'($urandom); end
    end
    n_cmp++;
    if (pulses != 3) begin n_fail++; $display("FAIL held_pulses got %0d want 3", pulses); end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_reset_mid_run();
    int pulses = 0;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h01; bi8 = 1'b0; s8 = 1'b1;
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy8, done8, d8, bo8} !== 11'd0) begin n_fail++; $display("FAIL mid_reset got %b want 0", {busy8, done8, d8, bo8}); end
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_fail++; $display("FAIL mid_reset_pulses got %0d want 0", pulses); end
    run_op(1'b0, 8'hAA, 8'h01, 1'b0);
  endtask
  task automatic test_random();
    repeat (24) run_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask
  task automatic test_width1();
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v = 3'(k);
      run_op(1'b1, {7'b0, v[2]}, {7'b0, v[1]}, v[0]);
    end
    repeat (6) run_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask
  initial begin
    test_reset();
    test_directed();
    test_held_start();
    test_reset_mid_run();
    test_random();
    test_width1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
